// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  localparam int unsigned DivWidth = 32;

  // Quotient reported for a zero divisor.
  localparam logic [DivWidth-1:0] DivZeroQuot = '1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient bit per clock,
// sign fix-up afterwards. Quotient truncates toward zero; remainder takes the dividend's sign.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   dmag_q, dmag_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dsr_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // |0x80..0| is 0x80..0 read as unsigned, so WIDTH bits suffice for the dividend magnitude.
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dsr_mag = {1'b0, (divisor[WIDTH-1] ? -divisor : divisor)};
  assign shifted = {rem_q, q_q[WIDTH-1]};
  assign trial   = shifted - dmag_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    rem_d      = rem_q;
    dmag_d     = dmag_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d  = dividend[WIDTH-1];
          q_d        = dvd_mag;
          rem_d      = '0;
          dmag_d     = dsr_mag;
          dbz_d      = (divisor == '0);
          if (divisor == '0) begin
            quot_out_d = '1;
            rem_out_d  = dividend;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = StDone;
          end else begin
            cnt_d   = CNT_W'(WIDTH - 1);
            busy_d  = 1'b1;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        // Trial subtract never underflows WIDTH+1 bits since rem < |divisor| <= 2**(WIDTH-1).
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        quot_out_d = neg_quot_q ? -q_q : q_q;
        rem_out_d  = neg_rem_q ? -rem_q : rem_q;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      q_q        <= '0;
      rem_q      <= '0;
      dmag_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      rem_q      <= rem_d;
      dmag_q     <= dmag_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases, reset abort, ignored start, random pairs.
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint x, y;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      e.q = W'(x / y); e.r = W'(x % y); e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Present operands with start for one cycle, then scramble operands to prove they were latched.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e,
                        input bit push);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
  endtask

  task automatic wait_done(output int cyc, output int nbusy, output bit to);
    cyc = 0; nbusy = 0; to = 1'b0;
    forever begin
      if (busy) nbusy++;
      if (done === 1'b1) break;
      if (cyc >= 200) begin to = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b done=%b q=%h r=%h, want all 0",
               busy, done, quotient, remainder);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[8] = '{32'h22, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000,
                            32'h8000_0000, 32'd7, 32'd5};
    logic [W-1:0] tb[8] = '{32'h24, 32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                            32'd1, 32'h8000_0000, 32'd0};
    logic [W-1:0] tq[8] = '{32'h0, 32'hE, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000,
                            32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    logic [W-1:0] tr[8] = '{32'h22, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                            32'd0, 32'd7, 32'd5};
    int   cyc, nbusy;
    bit   to;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.q = tq[i]; e.r = tr[i]; e.dbz = (tb[i] == '0);
      launch(ta[i], tb[i], e, 1'b1);
      wait_done(cyc, nbusy, to);
      n_checks++;
      if (to) begin
        n_fail++;
        $display("FAIL directed%0d_timeout: no done within %0d cycles", i, cyc);
        continue;
      end
      e = sb.pop_front();
      n_checks++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        n_fail++;
        $display("FAIL directed%0d_result: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                 i, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
      n_checks++;
      if (cyc !== (e.dbz ? 0 : W + 1) || nbusy !== (e.dbz ? 0 : W + 1)) begin
        n_fail++;
        $display("FAIL directed%0d_latency: got done@%0d busy=%0d, want %0d and %0d",
                 i, cyc, nbusy, e.dbz ? 0 : W + 1, e.dbz ? 0 : W + 1);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
        n_fail++;
        $display("FAIL directed%0d_hold: got done=%b busy=%b q=%h r=%h, want 0 0 %h %h",
                 i, done, busy, quotient, remainder, e.q, e.r);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc, nbusy;
    bit   to;
    bit   seen = 1'b0;
    e = '0;
    launch(32'd100, 32'd7, e, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got done pulse after abort, want none");
    end
    e.q = 32'd3; e.r = 32'd0; e.dbz = 1'b0;
    launch(32'd9, 32'd3, e, 1'b1);
    wait_done(cyc, nbusy, to);
    e = sb.pop_front();
    n_checks++;
    if (to || quotient !== e.q || remainder !== e.r) begin
      n_fail++;
      $display("FAIL after_reset_9_3: got q=%h r=%h timeout=%b, want q=%h r=%h",
               quotient, remainder, to, e.q, e.r);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   cyc, nbusy;
    bit   to;
    bit   seen = 1'b0;
    e.q = 32'd14; e.r = 32'd2; e.dbz = 1'b0;
    launch(32'd100, 32'd7, e, 1'b1);
    repeat (4) @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, nbusy, to);
    e = sb.pop_front();
    n_checks++;
    if (to || cyc !== W + 1 - 5 || quotient !== e.q || remainder !== e.r) begin
      n_fail++;
      $display("FAIL ignore_start: got q=%h r=%h cyc=%0d to=%b, want q=%h r=%h cyc=%0d",
               quotient, remainder, cyc, to, e.q, e.r, W + 1 - 5);
    end
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL ignore_start_extra: got extra busy/done, want idle");
    end
  endtask

  // start held from the done cycle: ignored in DONE, accepted one cycle later in IDLE.
  task automatic test_back_to_back();
    exp_t e;
    int   cyc, nbusy;
    bit   to;
    e = model(32'd1000, 32'd33);
    launch(32'd1000, 32'd33, e, 1'b1);
    wait_done(cyc, nbusy, to);
    e = sb.pop_front();
    n_checks++;
    if (to || quotient !== e.q || remainder !== e.r) begin
      n_fail++;
      $display("FAIL b2b_first: got q=%h r=%h, want q=%h r=%h", quotient, remainder, e.q, e.r);
    end
    dividend = 32'hFFFF_FC18; divisor = 32'd33; start = 1'b1;
    sb.push_back(model(32'hFFFF_FC18, 32'd33));
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start_in_done: got busy=%b done=%b, want 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, nbusy, to);
    e = sb.pop_front();
    n_checks++;
    if (to || cyc !== W + 1 || quotient !== e.q || remainder !== e.r) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%h r=%h cyc=%0d, want q=%h r=%h cyc=%0d",
               quotient, remainder, cyc, e.q, e.r, W + 1);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, back;
    exp_t         e;
    int           cyc, nbusy;
    bit           to;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0:       b = W'($urandom_range(1, 255));
        1:       b = -W'($urandom_range(1, 65535));
        default: b = $urandom;
      endcase
      if (b == '0) b = 32'd1;
      launch(a, b, model(a, b), 1'b1);
      wait_done(cyc, nbusy, to);
      e = sb.pop_front();
      n_checks++;
      if (to || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL random%0d %h/%h: got q=%h r=%h to=%b, want q=%h r=%h",
                 i, a, b, quotient, remainder, to, e.q, e.r);
      end
      back = quotient * b + remainder;
      n_checks++;
      if (back !== a) begin
        n_fail++;
        $display("FAIL random%0d_invariant: got q*d+r=%h, want %h", i, back, a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle signed 32-bit divider that sits between the datapath's Y register/bus and the 64-bit Z register.
- When the DIV step begins, it latches the dividend (from Y) and the divisor (from the bus).
- It iterates one quotient bit per clock using restoring division on magnitudes.
- It presents the quotient (Z low / LO) and remainder (Z high / HI) with a done pulse, so the control sequencer can hold Zin until done.

Parameters:
WIDTH, 32, operand width in bits; quotient and remainder are each WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  begin a division; sampled only in IDLE
dividend  input  WIDTH  signed dividend (Y register output)
divisor  input  WIDTH  signed divisor (BusMuxOut)
busy  output  1  high from the cycle after start is accepted until done is asserted
done  output  1  one-cycle pulse; outputs are valid on and after this cycle
quotient  output  WIDTH  signed quotient, goes to Z low / LO
remainder  output  WIDTH  signed remainder, goes to Z high / HI
div_by_zero  output  1  set with done when the latched divisor was 0

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and internal registers cleared.
  - Reset mid-operation abandons the division with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at a clock edge:
  - latch dividend and divisor; record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - load the magnitude |dividend| into the working quotient and clear the partial remainder.
  - If divisor==0: go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
  - Otherwise: go to CALC with counter=WIDTH-1 and busy=1.
- IDLE, start=0: hold; outputs keep their last result.
- CALC, one iteration per cycle:
  - shift {rem,q} left 1; trial = rem - |divisor| (WIDTH+1 bits).
  - If trial is non-negative: rem=trial and q[0]=1; otherwise q[0]=0.
  - When counter==0, go to FIX; otherwise decrement the counter.
  - Exactly WIDTH CALC cycles.
- FIX:
  - quotient = sign_q ? -q : q; remainder = sign_r ? -rem : rem (two's complement, truncated to WIDTH); go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - quotient and remainder hold until the next accepted start.
- Latency: start sampled at edge k gives done high in the cycle after edge k+WIDTH+1 (WIDTH+2 cycles). Divide by zero: done in the cycle after edge k.
- Rounding: the quotient truncates toward zero, and the remainder takes the dividend's sign. Invariant for every divisor != 0: dividend == quotient*divisor + remainder (mod 2**WIDTH).
- Overflow: 0x80000000 / -1 gives quotient=0x80000000 and remainder=0 with no flag. This is natural wrap; magnitudes use WIDTH+1-bit internal width.
- Operand changes: start while busy or in DONE is ignored. Dividend and divisor may change after the accepting edge without effect.
- div_by_zero is cleared when the next start is accepted.
- done and start in the same cycle: no new division. The sequencer must reassert start in IDLE.

Decomposition:
- Shared package div_pkg: state enum (IDLE=2'b00, CALC=2'b01, FIX=2'b10, DONE=2'b11), DIV_ZERO_QUOT constant (all ones), and the WIDTH default.
- No sub-module is required. An optional combinational abs_neg helper (two's-complement magnitude/negate) may be factored out and reused by the ALU NEG path.

Test Plan:
- dividend=0x00000022, divisor=0x00000024, start pulse -> done after 34 cycles, quotient=0x00000000, remainder=0x00000022, div_by_zero=0.
- dividend=100, divisor=7 -> quotient=14 (0x0000000E), remainder=2; busy high for exactly 33 cycles.
- dividend=-7 (0xFFFFFFF9), divisor=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Repeat with divisor=-2 -> quotient=3, remainder=-1.
- dividend=0x80000000, divisor=0xFFFFFFFF -> quotient=0x80000000, remainder=0. Then dividend=5, divisor=0 -> done one cycle after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- Start 100/7, pull reset low at CALC cycle 10 for 1 cycle -> all outputs 0 immediately, no done pulse. Start 9/3 afterwards -> quotient=3, remainder=0.
- Start 100/7, pulse start again with 50/5 at cycle 5 -> ignored; result is still 14/2. Random 1000 signed pairs (divisor != 0) checked against the invariant and a behavioural reference.
